pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: opcode  in  6  instruction bits [31:26], valid in DECODE.
REQ-004 SHALL have ports: funct  in  6  instruction bits [5:0], valid in DECODE.
REQ-005 SHALL have ports: alu_zero  in  1  ALU zero flag, valid in BRANCH.
REQ-006 SHALL have ports: mem_ready  in  1  instruction memory acknowledge for the current fetch.
REQ-007 SHALL have ports: exec_done  in  1  datapath controller has finished a non-PC instruction.
REQ-008 SHALL have ports: pc_load  out  1  PC register write enable, i.e. pc_write OR (pc_write_cond AND taken).
REQ-009 SHALL have ports: pc_source  out  2  PC mux select: 00 ALU result, 01 ALUOut branch target, 10 jump target, 11 exception vector.
REQ-010 SHALL have ports: iord  out  1  address mux select: 0 PC, 1 ALUOut.
REQ-011 SHALL have ports: ir_write  out  1  instruction register load.
REQ-012 SHALL have ports: epc_write  out  1  EPC register load.
REQ-013 SHALL have ports: ra_write  out  1  link register write for jal.
REQ-014 SHALL have ports: cause  out  2  last exception cause: 00 none, 01 invalid opcode, 10 fetch timeout.
REQ-015 SHALL have ports: state  out  3  current state encoding, for debug.

Function
REQ-016 SHALL encode its states as RESET=0, FETCH=1, DECODE=2, BRANCH=3, JUMP=4, JR=5, EXEC=6, EXCEPT=7.
REQ-017 SHALL produce all outputs combinationally from the registered state and the current inputs; outputs not listed for a state are 0.
REQ-018 RESET SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-019 FETCH SHALL drive iord=0; with mem_ready=1 it SHALL drive ir_write=1, pc_load=1 and pc_source=00 (PC+4), then go to DECODE.
REQ-020 FETCH SHALL count cycles with mem_ready=0 in a 4-bit timeout counter, cleared on entry to FETCH.
REQ-021 If mem_ready=0 on the 16th consecutive FETCH cycle, FETCH SHALL go to EXCEPT with cause 10; mem_ready=1 on that cycle SHALL win.
REQ-022 DECODE SHALL be a single cycle with no PC write.
REQ-023 DECODE SHALL transition on opcode 04/05 to BRANCH and on 02/03 to JUMP.
REQ-024 DECODE SHALL go to JR on opcode 00 with funct 08.
REQ-025 DECODE SHALL go to EXEC on opcodes 00 (other funct), 08, 0F, 23 and 2B.
REQ-026 DECODE SHALL go to EXCEPT with cause 01 on any other opcode.
REQ-027 BRANCH SHALL drive pc_write_cond with pc_source=01, then go to FETCH.
REQ-028 In BRANCH, taken SHALL be alu_zero for beq (04) and NOT alu_zero for bne (05).
REQ-029 In BRANCH, pc_load SHALL equal taken.
REQ-030 JUMP SHALL drive pc_load=1 and pc_source=10, then go to FETCH.
REQ-031 JUMP SHALL also drive ra_write=1 when the latched opcode is 03.
REQ-032 JR SHALL drive pc_load=1 and pc_source=00 (ALU passes rs), then go to FETCH.
REQ-033 EXEC SHALL hold with no PC write while exec_done=0 and go to FETCH on exec_done=1.
REQ-034 EXEC SHALL ignore exec_done in every other state.
REQ-035 EXCEPT SHALL last one cycle: epc_write=1, pc_load=1, pc_source=11, then FETCH.
REQ-036 The opcode SHALL be latched internally in DECODE and used by BRANCH and JUMP, so input changes after DECODE have no effect.
REQ-037 cause SHALL update only on entry to EXCEPT and hold until the next exception or reset.
REQ-038 pc_load SHALL never be asserted in RESET, DECODE or EXEC.

Reset
REQ-039 Assertion of reset_n=0 SHALL immediately, independent of clk, force state=RESET, cause=00, timeout counter=0 and latched opcode=0.
REQ-040 Reset assertion mid-instruction, in any state, SHALL abort the sequence with no further pc_load.
REQ-041 After reset_n returns to 1, the first rising edge SHALL enter RESET->FETCH, so the first fetch acknowledge is accepted on the second edge at the earliest.

Verification
REQ-042 Reset release, mem_ready=1 constantly, opcode 08, exec_done=1 -> state sequence 0,1,2,6,1; pc_load=1 only in FETCH with pc_source=00.
REQ-043 beq with alu_zero=1 -> BRANCH cycle shows pc_load=1, pc_source=01; repeat with alu_zero=0 -> pc_load=0; bne with alu_zero=0 -> pc_load=1.
REQ-044 jal (03) -> JUMP cycle shows pc_load=1, pc_source=10, ra_write=1; j (02) -> ra_write=0.
REQ-045 opcode 3F in DECODE -> EXCEPT next cycle with epc_write=1, pc_source=11, cause=01, then FETCH.
REQ-046 mem_ready held 0 for 16 FETCH cycles -> EXCEPT, cause=10; mem_ready=1 on cycle 16 -> DECODE, cause unchanged.
REQ-047 reset_n=0 pulsed while in EXEC -> state=0, all outputs 0 before the next clk edge; no pc_load.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: multi-cycle control FSM that owns every write of the program counter.
// Fetch with timeout, decode, branch/jump/jr/exec dispatch, and a one-cycle exception
// step. Outputs are decoded combinationally from the registered state and current inputs.
module pc_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  input  logic       exec_done,
  output logic       pc_load,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       ir_write,
  output logic       epc_write,
  output logic       ra_write,
  output logic [1:0] cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StBranch = 3'd3,
    StJump   = 3'd4,
    StJr     = 3'd5,
    StExec   = 3'd6,
    StExcept = 3'd7
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseInvalid = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  state_e     state_q;
  logic [3:0] tmo_q;    // consecutive FETCH cycles without mem_ready
  logic [5:0] op_q;     // opcode captured in DECODE for BRANCH/JUMP
  logic [1:0] cause_q;

  state_e     dec_next;
  logic       taken;

  // Dispatch target for the opcode/funct presented during DECODE.
  always_comb begin
    dec_next = StExcept;
    unique case (opcode)
      OpBeq, OpBne:               dec_next = StBranch;
      OpJ, OpJal:                 dec_next = StJump;
      OpRtype:                    dec_next = (funct == FnJr) ? StJr : StExec;
      OpAddi, OpLui, OpLw, OpSw:  dec_next = StExec;
      default:                    dec_next = StExcept;
    endcase
  end

  // Branch condition uses the latched opcode so late input changes cannot flip it.
  assign taken = (op_q == OpBne) ? ~alu_zero : alu_zero;

  // State register, fetch timeout counter, latched opcode and exception cause.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StReset;
      tmo_q   <= '0;
      op_q    <= '0;
      cause_q <= CauseNone;
    end else begin
      // Counter only survives while staying in FETCH, so it is clear on every entry.
      tmo_q <= '0;
      unique case (state_q)
        StReset: state_q <= StFetch;
        StFetch: begin
          if (mem_ready) begin
            state_q <= StDecode;
          end else if (tmo_q == 4'd15) begin
            state_q <= StExcept;
            cause_q <= CauseTimeout;
          end else begin
            tmo_q <= tmo_q + 4'd1;
          end
        end
        StDecode: begin
          op_q    <= opcode;
          state_q <= dec_next;
          if (dec_next == StExcept) cause_q <= CauseInvalid;
        end
        StBranch, StJump, StJr, StExcept: state_q <= StFetch;
        StExec: if (exec_done) state_q <= StFetch;
        default: state_q <= StReset;
      endcase
    end
  end

  // Per-state control outputs; anything not named for a state stays 0.
  always_comb begin
    pc_load   = 1'b0;
    pc_source = 2'b00;
    iord      = 1'b0;
    ir_write  = 1'b0;
    epc_write = 1'b0;
    ra_write  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_load  = 1'b1;
        end
      end
      StBranch: begin
        pc_source = 2'b01;
        pc_load   = taken;
      end
      StJump: begin
        pc_load   = 1'b1;
        pc_source = 2'b10;
        ra_write  = (op_q == OpJal);
      end
      StJr: pc_load = 1'b1;
      StExcept: begin
        epc_write = 1'b1;
        pc_load   = 1'b1;
        pc_source = 2'b11;
      end
      default: ;
    endcase
  end

  assign cause = cause_q;
  assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one task per scenario, inline checks.
module tb_pc_sequencer;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       exec_done;
  logic       pc_load;
  logic [1:0] pc_source;
  logic       iord;
  logic       ir_write;
  logic       epc_write;
  logic       ra_write;
  logic [1:0] cause;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .funct     (funct),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .exec_done (exec_done),
    .pc_load   (pc_load),
    .pc_source (pc_source),
    .iord      (iord),
    .ir_write  (ir_write),
    .epc_write (epc_write),
    .ra_write  (ra_write),
    .cause     (cause),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Apply reset between edges and release it; returns in the first FETCH cycle.
  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    exec_done = 1'b0;
    alu_zero  = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // From a FETCH cycle: acknowledge the fetch, present the instruction, land in DECODE,
  // then take one more edge into the dispatched state.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    mem_ready = 1'b1;
    opcode    = op;
    funct     = fn;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    exec_done = 1'b1;
    alu_zero  = 1'b1;
    opcode    = 6'h08;
    funct     = 6'h00;
    #3;
    n_checks++;
    if (state !== 3'd0) begin
      n_errors++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    n_checks++;
    if ({pc_load, pc_source, iord, ir_write, epc_write, ra_write} !== 7'd0) begin
      n_errors++; $display("FAIL reset_outputs got=%b exp=0000000",
                           {pc_load, pc_source, iord, ir_write, epc_write, ra_write});
    end
    n_checks++;
    if (cause !== 2'b00) begin
      n_errors++; $display("FAIL reset_cause got=%b exp=00", cause);
    end
    // Edges while held in reset must not advance.
    tick();
    n_checks++;
    if (state !== 3'd0) begin
      n_errors++; $display("FAIL reset_hold_state got=%0d exp=0", state);
    end
  endtask

  // Reset release, addi with exec_done=1: 0,1,2,6,1 and PC written only in FETCH.
  task automatic test_exec_sequence();
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    exec_done = 1'b1;
    opcode    = 6'h08;
    funct     = 6'h00;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || pc_load !== 1'b0) begin
      n_errors++; $display("FAIL seq_s0 got=%0d/%b exp=0/0", state, pc_load);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || pc_load !== 1'b1 || pc_source !== 2'b00 || ir_write !== 1'b1
        || iord !== 1'b0) begin
      n_errors++; $display("FAIL seq_fetch got=%0d/%b/%b/%b/%b exp=1/1/00/1/0",
                           state, pc_load, pc_source, ir_write, iord);
    end
    tick();
    n_checks++;
    if (state !== 3'd2 || pc_load !== 1'b0 || ir_write !== 1'b0) begin
      n_errors++; $display("FAIL seq_decode got=%0d/%b/%b exp=2/0/0", state, pc_load, ir_write);
    end
    tick();
    n_checks++;
    if (state !== 3'd6 || pc_load !== 1'b0) begin
      n_errors++; $display("FAIL seq_exec got=%0d/%b exp=6/0", state, pc_load);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || pc_load !== 1'b1) begin
      n_errors++; $display("FAIL seq_refetch got=%0d/%b exp=1/1", state, pc_load);
    end
  endtask

  task automatic test_branch();
    do_reset();
    // beq, zero set: taken. Opcode input flipped to bne in BRANCH must not matter.
    alu_zero = 1'b1;
    fetch_decode(6'h04, 6'h00);
    opcode = 6'h05;
    #1;
    n_checks++;
    if (state !== 3'd3 || pc_load !== 1'b1 || pc_source !== 2'b01) begin
      n_errors++; $display("FAIL beq_taken got=%0d/%b/%b exp=3/1/01", state, pc_load, pc_source);
    end
    tick();
    n_checks++;
    if (state !== 3'd1) begin
      n_errors++; $display("FAIL branch_return got=%0d exp=1", state);
    end
    // beq, zero clear: not taken.
    alu_zero = 1'b0;
    fetch_decode(6'h04, 6'h00);
    n_checks++;
    if (state !== 3'd3 || pc_load !== 1'b0 || pc_source !== 2'b01) begin
      n_errors++; $display("FAIL beq_not_taken got=%0d/%b/%b exp=3/0/01",
                           state, pc_load, pc_source);
    end
    tick();
    // bne, zero clear: taken.
    fetch_decode(6'h05, 6'h00);
    n_checks++;
    if (state !== 3'd3 || pc_load !== 1'b1) begin
      n_errors++; $display("FAIL bne_taken got=%0d/%b exp=3/1", state, pc_load);
    end
    alu_zero = 1'b1;
    #1;
    n_checks++;
    if (pc_load !== 1'b0) begin
      n_errors++; $display("FAIL bne_zero got=%b exp=0", pc_load);
    end
    tick();
  endtask

  task automatic test_jump();
    do_reset();
    fetch_decode(6'h03, 6'h00);
    n_checks++;
    if (state !== 3'd4 || pc_load !== 1'b1 || pc_source !== 2'b10 || ra_write !== 1'b1) begin
      n_errors++; $display("FAIL jal got=%0d/%b/%b/%b exp=4/1/10/1",
                           state, pc_load, pc_source, ra_write);
    end
    tick();
    fetch_decode(6'h02, 6'h00);
    n_checks++;
    if (state !== 3'd4 || pc_load !== 1'b1 || pc_source !== 2'b10 || ra_write !== 1'b0) begin
      n_errors++; $display("FAIL j got=%0d/%b/%b/%b exp=4/1/10/0",
                           state, pc_load, pc_source, ra_write);
    end
    tick();
    fetch_decode(6'h00, 6'h08);
    n_checks++;
    if (state !== 3'd5 || pc_load !== 1'b1 || pc_source !== 2'b00) begin
      n_errors++; $display("FAIL jr got=%0d/%b/%b exp=5/1/00", state, pc_load, pc_source);
    end
    tick();
    // R-type other than jr goes to EXEC.
    exec_done = 1'b1;
    fetch_decode(6'h00, 6'h20);
    n_checks++;
    if (state !== 3'd6 || pc_load !== 1'b0) begin
      n_errors++; $display("FAIL rtype_exec got=%0d/%b exp=6/0", state, pc_load);
    end
    tick();
  endtask

  task automatic test_invalid_opcode();
    do_reset();
    fetch_decode(6'h3F, 6'h00);
    n_checks++;
    if (state !== 3'd7 || epc_write !== 1'b1 || pc_load !== 1'b1 || pc_source !== 2'b11
        || cause !== 2'b01) begin
      n_errors++; $display("FAIL except_invalid got=%0d/%b/%b/%b/%b exp=7/1/1/11/01",
                           state, epc_write, pc_load, pc_source, cause);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || cause !== 2'b01 || epc_write !== 1'b0) begin
      n_errors++; $display("FAIL except_return got=%0d/%b/%b exp=1/01/0", state, cause, epc_write);
    end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    // First FETCH cycle is now current; 15 more starved cycles keep us in FETCH.
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++;
    if (state !== 3'd1 || pc_load !== 1'b0 || ir_write !== 1'b0) begin
      n_errors++; $display("FAIL timeout_cycle16 got=%0d/%b/%b exp=1/0/0",
                           state, pc_load, ir_write);
    end
    tick();
    n_checks++;
    if (state !== 3'd7 || cause !== 2'b10 || epc_write !== 1'b1) begin
      n_errors++; $display("FAIL timeout_except got=%0d/%b/%b exp=7/10/1", state, cause, epc_write);
    end
    tick();
    // Ready arriving exactly on the 16th starved cycle wins.
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    opcode    = 6'h08;
    exec_done = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd1 || ir_write !== 1'b1 || pc_load !== 1'b1) begin
      n_errors++; $display("FAIL timeout_ready_wins got=%0d/%b/%b exp=1/1/1",
                           state, ir_write, pc_load);
    end
    tick();
    n_checks++;
    if (state !== 3'd2 || cause !== 2'b10) begin
      n_errors++; $display("FAIL timeout_decode got=%0d/%b exp=2/10", state, cause);
    end
  endtask

  // Continues from DECODE of addi with exec_done=0.
  task automatic test_exec_hold_and_reset();
    tick();
    tick();
    n_checks++;
    if (state !== 3'd6 || pc_load !== 1'b0) begin
      n_errors++; $display("FAIL exec_hold got=%0d/%b exp=6/0", state, pc_load);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || cause !== 2'b00
        || {pc_load, pc_source, iord, ir_write, epc_write, ra_write} !== 7'd0) begin
      n_errors++; $display("FAIL exec_async_reset got=%0d/%b/%b exp=0/00/0000000", state, cause,
                           {pc_load, pc_source, iord, ir_write, epc_write, ra_write});
    end
    exec_done = 1'b1;
    tick();
    n_checks++;
    if (state !== 3'd0 || pc_load !== 1'b0) begin
      n_errors++; $display("FAIL exec_reset_held got=%0d/%b exp=0/0", state, pc_load);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;
    exec_done = 1'b0;
    test_reset();
    test_exec_sequence();
    test_branch();
    test_jump();
    test_invalid_opcode();
    test_fetch_timeout();
    test_exec_hold_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
